mem_bus_debug_bridge: RTL and testbench
=======================================

// Module: mem_bus_debug_bridge
// PURPOSE
//  Byte-stream-to-memory-bus initiator: parses host commands (from a UART/USB byte pipe) and
//  issues single reads/writes on the core memory bus, the initiator side of the memory-map
//  decode in top. Takes the bus through a request/grant arbiter; used to load programs and
//  to peek/poke memory-mapped registers.
// PARAMETERS
//  TIMEOUT_CYCLES  240000  clk24 cycles with no rx byte mid-command before discard (10 ms)
//  ACK_BYTE        8'hA5   response byte for a successful command
//  NAK_BYTE        8'hEE   response byte for bad opcode or misaligned address
// PORTS
//  clk24                           in   1   bus clock
//  reset                           in   1   asynchronous, active-high
//  rx_data                         in   8   command byte
//  rx_valid                        in   1   rx_data valid
//  rx_ready                        out  1   byte accepted when rx_valid & rx_ready
//  tx_data                         out  8   response byte
//  tx_valid                        out  1   tx_data valid; held until tx_ready
//  tx_ready                        in   1   consumer accepts tx_data
//  bus_request                     out  1   request ownership of memory bus
//  bus_grant                       in   1   arbiter grants bus (core stalled)
//  memory_address                  out  32  byte address
//  unshifted_memory_write_value    out  32  write data, LSB-aligned
//  unshifted_memory_write_sections out  3   {upper half, byte1, byte0}; 0 = no write
//  memory_read_value               in   32  read data, already right-shifted, 1 cycle after address
//  busy                            out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, all outputs 0, rx_ready 0 during reset, 1 in IDLE afterwards.
//  Command: opcode, 4 address bytes LE, then for writes 4 data bytes LE (always 4; unused upper
//   bytes ignored). Opcodes: 10/11/12 = write byte/half/word; 20/21/22 = read byte/half/word.
//  States: IDLE -> ADDR (4 bytes) -> DATA (writes only, 4 bytes) -> REQ -> ACCESS -> [RDWAIT] -> RESP -> IDLE.
//  IDLE: unknown opcode -> RESP with NAK_BYTE, no bus activity.
//  After last address/data byte: misaligned (half with a[0]=1, word with a[1:0]!=0) -> NAK, no request.
//  rx_ready = 1 only in IDLE/ADDR/DATA; 0 from REQ until return to IDLE.
//  REQ: bus_request=1; stays until bus_grant sampled 1; next cycle is ACCESS.
//  ACCESS (exactly one cycle): memory_address = latched address; sections = 001/011/111 for
//   write byte/half/word, 000 for reads. Outside ACCESS sections are 000, address holds last value.
//  Write: ACCESS -> RESP. Read: ACCESS -> RDWAIT; memory_read_value captured at end of RDWAIT,
//   masked to size (zero-extend byte/half) -> RESP.
//  bus_request deasserts in the cycle after ACCESS (write) or RDWAIT (read); held throughout ACCESS.
//  bus_grant dropping during ACCESS/RDWAIT is an arbiter error; bridge ignores it and completes.
//  RESP: ACK_BYTE, then for reads 4 data bytes LE; each byte held on tx_data with tx_valid=1 until
//   tx_ready; next byte presented the cycle after acceptance; IDLE after the final accept.
//  Timeout: 32-bit idle counter cleared on every accepted rx byte; in ADDR/DATA reaching
//   TIMEOUT_CYCLES discards the partial command -> IDLE, no response. Counter inactive elsewhere.
//  Reset mid-operation: state IDLE immediately; bus_request, tx_valid, sections forced 0;
//   partial command/response discarded.
// TESTING
//  1 write word 12 00010000 00 EFBEADDE -> one ACCESS cycle addr 0x00000100, value 0xDEADBEEF, sections 111; tx A5.
//  2 read half 21 02010000 00, bus returns 0xFFFF1234 -> sections 000; tx A5 34 12 00 00.
//  3 write half to 0x00000101 -> tx EE, bus_request never asserted; opcode 0x7F -> tx EE.
//  4 bus_grant held 0 for 50 cycles -> bus_request stays 1, rx_ready 0, no ACCESS; grant -> completes.
//  5 TIMEOUT_CYCLES=100: send 20 01 then stall 100 cycles -> back to IDLE, no tx; next full command OK.
//  6 tx_ready low 10 cycles per byte during read response -> tx_data stable; reset mid-RESP -> all outputs 0.

Source files
------------

// File: rtl/mem_bus_debug_bridge.sv
// mem_bus_debug_bridge: parses host command bytes (opcode, LE address, LE data)
// and performs one read or write on the core memory bus via request/grant,
// answering with ACK (plus read data) or NAK on the tx byte stream.
module mem_bus_debug_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 240000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  NAK_BYTE       = 8'hEE
) (
    input  logic        clk24,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic [31:0] memory_address,
    output logic [31:0] unshifted_memory_write_value,
    output logic [2:0]  unshifted_memory_write_sections,
    input  logic [31:0] memory_read_value,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_REQ, S_ACCESS, S_RDWAIT, S_RESP
    } state_t;

    state_t      state, next_state;
    logic        cmd_write;
    logic [1:0]  cmd_size;      // 0 byte, 1 half, 2 word
    logic [1:0]  byte_cnt;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] idle_cnt;
    logic [31:0] rd_data;
    logic [7:0]  resp_code;
    logic [2:0]  resp_idx;
    logic [2:0]  resp_last;
    logic        rx_fire;
    logic        last_byte;
    logic        timed_out;
    logic        load_nak;
    logic        load_wr_ack;
    logic        load_rd_ack;

    function automatic logic opcode_known(input logic [7:0] op);
        return op inside {8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
        logic m;
        unique case (size)
            2'd1:    m = a[0];
            2'd2:    m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Zero-extend the bus read value to the access size.
    function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] v);
        logic [31:0] r;
        unique case (size)
            2'd0:    r = {24'd0, v[7:0]};
            2'd1:    r = {16'd0, v[15:0]};
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] write_sections(input logic wr, input logic [1:0] size);
        logic [2:0] s;
        unique case (size)
            2'd0:    s = 3'b001;
            2'd1:    s = 3'b011;
            default: s = 3'b111;
        endcase
        return wr ? s : 3'b000;
    endfunction

    // Index 0 is the status byte, 1..4 are read data bytes LSB first.
    function automatic logic [7:0] response_byte(input logic [2:0] idx, input logic [7:0] code,
                                                 input logic [31:0] d);
        logic [7:0] b;
        unique case (idx)
            3'd1:    b = d[7:0];
            3'd2:    b = d[15:8];
            3'd3:    b = d[23:16];
            3'd4:    b = d[31:24];
            default: b = code;
        endcase
        return b;
    endfunction

    assign rx_fire   = rx_valid && rx_ready;
    assign last_byte = rx_fire && (byte_cnt == 2'd3);
    assign timed_out = !rx_fire && (idle_cnt >= TIMEOUT_CYCLES - 1);
    assign busy      = (state != S_IDLE);

    // State register; reset abandons any partial command or response.
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state decode and all handshake / bus strobes.
    always_comb begin
        next_state                      = state;
        rx_ready                        = 1'b0;
        tx_valid                        = 1'b0;
        tx_data                         = 8'h00;
        bus_request                     = 1'b0;
        unshifted_memory_write_sections = 3'b000;
        load_nak                        = 1'b0;
        load_wr_ack                     = 1'b0;
        load_rd_ack                     = 1'b0;
        unique case (state)
            S_IDLE: begin
                rx_ready = !reset;
                if (rx_fire) begin
                    if (opcode_known(rx_data)) begin
                        next_state = S_ADDR;
                    end else begin
                        next_state = S_RESP;
                        load_nak   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                rx_ready = 1'b1;
                if (last_byte) begin
                    if (cmd_write) begin
                        next_state = S_DATA;
                    end else if (misaligned(cmd_size, cmd_addr[1:0])) begin
                        next_state = S_RESP;
                        load_nak   = 1'b1;
                    end else begin
                        next_state = S_REQ;
                    end
                end else if (timed_out) begin
                    next_state = S_IDLE;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (last_byte) begin
                    if (misaligned(cmd_size, cmd_addr[1:0])) begin
                        next_state = S_RESP;
                        load_nak   = 1'b1;
                    end else begin
                        next_state = S_REQ;
                    end
                end else if (timed_out) begin
                    next_state = S_IDLE;
                end
            end
            S_REQ: begin
                bus_request = 1'b1;
                if (bus_grant) next_state = S_ACCESS;
            end
            S_ACCESS: begin
                bus_request                     = 1'b1;
                unshifted_memory_write_sections = write_sections(cmd_write, cmd_size);
                if (cmd_write) begin
                    next_state  = S_RESP;
                    load_wr_ack = 1'b1;
                end else begin
                    next_state = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                bus_request = 1'b1;
                next_state  = S_RESP;
                load_rd_ack = 1'b1;
            end
            S_RESP: begin
                tx_valid = 1'b1;
                tx_data  = response_byte(resp_idx, resp_code, rd_data);
                if (tx_ready && (resp_idx == resp_last)) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Command capture, idle timeout counter, bus address/data and response sequencing.
    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            cmd_write                    <= 1'b0;
            cmd_size                     <= 2'd0;
            byte_cnt                     <= 2'd0;
            cmd_addr                     <= 32'd0;
            cmd_data                     <= 32'd0;
            idle_cnt                     <= 32'd0;
            rd_data                      <= 32'd0;
            resp_code                    <= 8'h00;
            resp_idx                     <= 3'd0;
            resp_last                    <= 3'd0;
            memory_address               <= 32'd0;
            unshifted_memory_write_value <= 32'd0;
        end else begin
            if (state == S_IDLE) begin
                byte_cnt <= 2'd0;
                if (rx_fire) begin
                    cmd_write <= (rx_data[7:4] == 4'h1);
                    cmd_size  <= rx_data[1:0];
                end
            end else if (rx_fire) begin
                byte_cnt <= byte_cnt + 2'd1;
                if (state == S_ADDR) cmd_addr[{byte_cnt, 3'b000} +: 8] <= rx_data;
                else                 cmd_data[{byte_cnt, 3'b000} +: 8] <= rx_data;
            end

            if (rx_fire || !((state == S_ADDR) || (state == S_DATA))) idle_cnt <= 32'd0;
            else                                                    idle_cnt <= idle_cnt + 32'd1;

            if ((state == S_REQ) && bus_grant) begin
                memory_address               <= cmd_addr;
                unshifted_memory_write_value <= cmd_data;
            end

            if (load_nak || load_wr_ack) begin
                resp_code <= load_nak ? NAK_BYTE : ACK_BYTE;
                resp_idx  <= 3'd0;
                resp_last <= 3'd0;
            end else if (load_rd_ack) begin
                resp_code <= ACK_BYTE;
                resp_idx  <= 3'd0;
                resp_last <= 3'd4;
                rd_data   <= size_mask(cmd_size, memory_read_value);
            end else if ((state == S_RESP) && tx_ready && (resp_idx != resp_last)) begin
                resp_idx <= resp_idx + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_debug_bridge.sv
// Bench for mem_bus_debug_bridge: directed scenarios plus randomized commands
// checked against a byte-level protocol model.
module tb_mem_bus_debug_bridge;

    localparam int unsigned TO  = 100;
    localparam logic [7:0]  ACK = 8'hA5;
    localparam logic [7:0]  NAK = 8'hEE;

    logic        clk24 = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        bus_request;
    logic        bus_grant;
    logic        grant_en = 1'b1;
    logic [31:0] memory_address;
    logic [31:0] wr_value;
    logic [2:0]  wr_sec;
    logic [31:0] rd_val = 32'd0;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          acc_n = 0;
    int          req_n = 0;
    logic [31:0] acc_addr = 32'd0;
    logic [31:0] acc_val = 32'd0;
    logic [2:0]  acc_sec = 3'd0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    bit          tmo = 1'b0;
    bit          unstable = 1'b0;
    bit          exp_bus = 1'b0;
    logic [7:0]  ops [6] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};

    assign bus_grant = grant_en & bus_request;

    always #5 clk24 = ~clk24;

    mem_bus_debug_bridge #(
        .TIMEOUT_CYCLES(TO),
        .ACK_BYTE(ACK),
        .NAK_BYTE(NAK)
    ) dut (
        .clk24(clk24),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .bus_request(bus_request),
        .bus_grant(bus_grant),
        .memory_address(memory_address),
        .unshifted_memory_write_value(wr_value),
        .unshifted_memory_write_sections(wr_sec),
        .memory_read_value(rd_val),
        .busy(busy)
    );

    // Bus-side observer: records write strobes and request cycles.
    always @(negedge clk24) begin
        if (!reset) begin
            if (wr_sec != 3'b000) begin
                acc_n++;
                acc_addr = memory_address;
                acc_val  = wr_value;
                acc_sec  = wr_sec;
            end
            if (bus_request) begin
                req_n++;
                checks++;
                if (rx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_ready_while_bus actual=%b required=0", rx_ready);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [7:0] op);
        case (op)
            8'h10, 8'h20: return 1;
            8'h11, 8'h21: return 2;
            8'h12, 8'h22: return 4;
            default:      return 0;
        endcase
    endfunction

    function automatic bit writes(input logic [7:0] op);
        return (op == 8'h10) || (op == 8'h11) || (op == 8'h12);
    endfunction

    function automatic logic [31:0] low_mask(input int n);
        return (n >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    endfunction

    function automatic logic [2:0] sec_of(input int n);
        return (n == 1) ? 3'b001 : (n == 2) ? 3'b011 : 3'b111;
    endfunction

    task automatic build_expected(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rv);
        int n;
        logic [31:0] v;
        n = size_of(op);
        exp_q.delete();
        exp_bus = (n != 0);
        if (exp_bus) exp_bus = ((addr % 32'(n)) == 32'd0);
        if (!exp_bus) begin
            exp_q.push_back(NAK);
        end else begin
            exp_q.push_back(ACK);
            if (!writes(op)) begin
                v = rv & low_mask(n);
                for (int i = 0; i < 4; i++) exp_q.push_back(8'(v >> (8 * i)));
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk24);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk24);
            n++;
        end
        if (n >= 100) tmo = 1'b1;
        else @(posedge clk24);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic recv(input int nrx, input int stall);
        logic [7:0] d;
        int w;
        for (int k = 0; k < nrx; k++) begin
            w = 0;
            @(negedge clk24);
            while (tx_valid !== 1'b1 && w < 200) begin
                @(negedge clk24);
                w++;
            end
            if (w >= 200) begin
                tmo = 1'b1;
                return;
            end
            d = tx_data;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk24);
                if (tx_valid !== 1'b1 || tx_data !== d) unstable = 1'b1;
            end
            tx_ready = 1'b1;
            @(posedge clk24);
            #1;
            tx_ready = 1'b0;
            got_q.push_back(d);
        end
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input int stall, input int nrx);
        @(posedge clk24);
        #1;
        acc_n = 0; req_n = 0; got_q.delete(); tmo = 1'b0; unstable = 1'b0;
        send_byte(op);
        if (size_of(op) != 0) begin
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
            if (writes(op)) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
        end
        recv(nrx, stall);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        repeat (3) @(negedge clk24);
        checks++;
        if ({tx_valid, tx_data, bus_request, wr_sec, busy, rx_ready, memory_address, wr_value} !== '0) begin
            errors++;
            $display("FAIL reset_outputs actual=%b_%h_%b_%b_%b_%b_%h_%h required=all_zero",
                     tx_valid, tx_data, bus_request, wr_sec, busy, rx_ready, memory_address, wr_value);
        end
        reset = 1'b0;
        @(negedge clk24);
        checks++;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release actual=rdy%b busy%b required=rdy1 busy0", rx_ready, busy);
        end
    endtask

    task automatic test_write_word;
        run_cmd(8'h12, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1);
        checks++;
        if (tmo || got_q.size() != 1 || got_q[0] !== ACK) begin
            errors++;
            $display("FAIL wr_word_resp actual=%p tmo=%0d required=a5", got_q, tmo);
        end
        checks++;
        if (acc_n != 1 || acc_addr !== 32'h100 || acc_val !== 32'hDEAD_BEEF || acc_sec !== 3'b111) begin
            errors++;
            $display("FAIL wr_word_access actual=n%0d a%h v%h s%b required=n1 a00000100 vdeadbeef s111",
                     acc_n, acc_addr, acc_val, acc_sec);
        end
        checks++;
        if (req_n != 2) begin
            errors++;
            $display("FAIL wr_word_req_cycles actual=%0d required=2", req_n);
        end
        @(negedge clk24);
        checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_word_idle actual=busy%b txv%b required=0_0", busy, tx_valid);
        end
    endtask

    task automatic test_read_half;
        logic [7:0] want [5];
        want = '{8'hA5, 8'h34, 8'h12, 8'h00, 8'h00};
        rd_val = 32'hFFFF_1234;
        run_cmd(8'h21, 32'h0000_0102, 32'd0, 0, 5);
        checks++;
        if (tmo || got_q.size() != 5) begin
            errors++;
            $display("FAIL rd_half_len actual=%0d tmo=%0d required=5", got_q.size(), tmo);
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL rd_half_byte%0d actual=%h required=%h", i, got_q[i], want[i]);
                end
            end
        end
        checks++;
        if (acc_n != 0 || req_n != 3 || memory_address !== 32'h102) begin
            errors++;
            $display("FAIL rd_half_bus actual=wr%0d req%0d a%h required=wr0 req3 a00000102",
                     acc_n, req_n, memory_address);
        end
    endtask

    task automatic test_nak;
        run_cmd(8'h11, 32'h0000_0101, 32'h1234_5678, 0, 1);
        checks++;
        if (tmo || got_q.size() != 1 || got_q[0] !== NAK || req_n != 0 || acc_n != 0) begin
            errors++;
            $display("FAIL nak_misaligned_half actual=%p req%0d wr%0d required=ee req0 wr0", got_q, req_n, acc_n);
        end
        run_cmd(8'h22, 32'h0000_0002, 32'd0, 0, 1);
        checks++;
        if (tmo || got_q.size() != 1 || got_q[0] !== NAK || req_n != 0) begin
            errors++;
            $display("FAIL nak_misaligned_word actual=%p req%0d required=ee req0", got_q, req_n);
        end
        run_cmd(8'h7F, 32'd0, 32'd0, 0, 1);
        checks++;
        if (tmo || got_q.size() != 1 || got_q[0] !== NAK || req_n != 0) begin
            errors++;
            $display("FAIL nak_opcode actual=%p req%0d required=ee req0", got_q, req_n);
        end
    endtask

    task automatic test_grant_stall;
        logic [31:0] a, d;
        bit bad;
        int w;
        a = 32'h0000_0204;
        d = 32'hCAFE_F00D;
        @(posedge clk24);
        #1;
        acc_n = 0; req_n = 0; got_q.delete(); tmo = 1'b0; grant_en = 1'b0;
        send_byte(8'h12);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        w = 0;
        @(negedge clk24);
        while (bus_request !== 1'b1 && w < 20) begin
            @(negedge clk24);
            w++;
        end
        bad = (w >= 20);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk24);
            if (bus_request !== 1'b1 || rx_ready !== 1'b0 || wr_sec !== 3'b000 || tx_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad || acc_n != 0) begin
            errors++;
            $display("FAIL grant_stall_hold actual=bad%0d wr%0d required=bad0 wr0", bad, acc_n);
        end
        grant_en = 1'b1;
        recv(1, 0);
        checks++;
        if (tmo || got_q.size() != 1 || got_q[0] !== ACK || acc_n != 1 || acc_addr !== a || acc_val !== d) begin
            errors++;
            $display("FAIL grant_stall_done actual=%p wr%0d a%h v%h required=a5 wr1 a%h v%h",
                     got_q, acc_n, acc_addr, acc_val, a, d);
        end
    endtask

    task automatic test_timeout;
        bit b95, b105, seen;
        @(posedge clk24);
        #1;
        tmo = 1'b0;
        b95 = 1'b0; b105 = 1'b1; seen = 1'b0;
        send_byte(8'h20);
        send_byte(8'h01);
        for (int c = 1; c <= 110; c++) begin
            @(negedge clk24);
            if (c == 95)  b95  = busy;
            if (c == 105) b105 = busy;
            if (tx_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (tmo || b95 !== 1'b1 || b105 !== 1'b0 || seen) begin
            errors++;
            $display("FAIL timeout_discard actual=busy95_%b busy105_%b tx%0d required=1_0_0", b95, b105, seen);
        end
        run_cmd(8'h10, 32'h0000_0033, 32'h1122_335A, 0, 1);
        checks++;
        if (tmo || got_q.size() != 1 || got_q[0] !== ACK || acc_n != 1 || acc_addr !== 32'h33 ||
            acc_val[7:0] !== 8'h5A || acc_sec !== 3'b001) begin
            errors++;
            $display("FAIL timeout_recover actual=%p wr%0d a%h v%h s%b required=a5 wr1 a33 v..5a s001",
                     got_q, acc_n, acc_addr, acc_val, acc_sec);
        end
    endtask

    task automatic test_backpressure_reset;
        rd_val = $urandom | 32'h8000_0000;
        build_expected(8'h22, 32'h0000_0040, rd_val);
        run_cmd(8'h22, 32'h0000_0040, 32'd0, 10, 5);
        checks++;
        if (tmo || unstable || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL backpressure_hold actual=tmo%0d unstable%0d n%0d required=0_0_%0d",
                     tmo, unstable, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL backpressure_byte%0d actual=%h required=%h", i, got_q[i], exp_q[i]);
                end
            end
        end
        rd_val = $urandom;
        run_cmd(8'h20, 32'h0000_0041, 32'd0, 0, 2);
        @(negedge clk24);
        checks++;
        if (tmo || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_resp_pending actual=txv%b tmo%0d required=txv1", tx_valid, tmo);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_valid, tx_data, bus_request, wr_sec, busy, rx_ready, memory_address, wr_value} !== '0) begin
            errors++;
            $display("FAIL mid_resp_reset actual=%b_%h_%b_%b_%b_%b_%h_%h required=all_zero",
                     tx_valid, tx_data, bus_request, wr_sec, busy, rx_ready, memory_address, wr_value);
        end
        @(negedge clk24);
        reset = 1'b0;
        @(negedge clk24);
        checks++;
        if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_resp_release actual=rdy%b txv%b busy%b required=1_0_0", rx_ready, tx_valid, busy);
        end
    endtask

    task automatic test_random;
        logic [7:0]  op;
        logic [31:0] addr, data;
        int n;
        for (int it = 0; it < 40; it++) begin
            op   = ($urandom_range(0, 9) < 9) ? ops[$urandom_range(0, 5)] : 8'($urandom);
            addr = $urandom;
            if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
            data   = $urandom;
            rd_val = $urandom;
            n = size_of(op);
            build_expected(op, addr, rd_val);
            run_cmd(op, addr, data, $urandom_range(0, 2), exp_q.size());
            checks++;
            if (tmo || got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_len op=%h actual=%0d tmo=%0d required=%0d", it, op, got_q.size(), tmo, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_byte%0d op=%h a=%h actual=%h required=%h", it, i, op, addr, got_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (req_n != (exp_bus ? (writes(op) ? 2 : 3) : 0) || acc_n != ((exp_bus && writes(op)) ? 1 : 0)) begin
                errors++;
                $display("FAIL rand%0d_bus op=%h a=%h actual=req%0d wr%0d required=bus%0d", it, op, addr, req_n, acc_n, exp_bus);
            end
            if (exp_bus && writes(op)) begin
                checks++;
                if (acc_addr !== addr || (acc_val & low_mask(n)) !== (data & low_mask(n)) || acc_sec !== sec_of(n)) begin
                    errors++;
                    $display("FAIL rand%0d_write actual=a%h v%h s%b required=a%h v%h s%b", it, acc_addr,
                             acc_val & low_mask(n), acc_sec, addr, data & low_mask(n), sec_of(n));
                end
            end else if (exp_bus) begin
                checks++;
                if (memory_address !== addr) begin
                    errors++;
                    $display("FAIL rand%0d_read_addr actual=%h required=%h", it, memory_address, addr);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_word();
        test_read_half();
        test_nak();
        test_grant_stall();
        test_timeout();
        test_backpressure_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
